prog_load_ctrl: RTL

- Host-side sequencer for the single-cycle RISC core.
- Accepts a command stream over a valid/ready handshake and writes instruction and data memory through the core's external test-mode ports.
- Hands control to the core: drops test_normal, pulses the core clear, then counts cycles until the core signals halt.
- Replaces hand-written testbench load tasks with a reusable block that can sit between a UART/JTAG bridge and the core.

---
 rtl/prog_load_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/prog_load_ctrl.sv
// Host-side load/run sequencer for the single-cycle RISC core: memory writes over test-mode ports,
// core clear, run and halt detection. Define PROG_LOAD_WATCHDOG_EN to add the RUN-cycle watchdog.
module prog_load_ctrl #(
  parameter int CLR_CYCLES = 2,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000,
  parameter bit DONE_POL   = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [15:0]      cmd_addr,
  input  logic [15:0]      cmd_data,
  input  logic             abort,
  input  logic             cpu_done,
  output logic             test_normal,
  output logic             ext_instr_we,
  output logic [15:0]      ext_instr_addr,
  output logic [15:0]      ext_instr_data,
  output logic             ext_data_we,
  output logic [15:0]      ext_data_addr,
  output logic [15:0]      ext_data_data,
  output logic             cpu_clr,
  output logic             busy,
  output logic             run_done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_CLR, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state;
  logic             r_ready, w_ready;
  logic             r_test_normal, w_test_normal;
  logic             r_iwe, w_iwe, r_dwe, w_dwe;
  logic [15:0]      r_iaddr, w_iaddr, r_idata, w_idata;
  logic [15:0]      r_daddr, w_daddr, r_ddata, w_ddata;
  logic             r_cpu_clr, w_cpu_clr;
  logic             r_run_done, w_run_done;
  logic [CNT_W-1:0] r_count, w_count;
  logic [CLR_W-1:0] r_clr_cnt, w_clr_cnt;
  logic             w_done_act;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_done_act = (cpu_done == DONE_POL);

`ifdef PROG_LOAD_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);
  logic r_timeout, w_timeout;
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_state       = r_state;
    w_test_normal = r_test_normal;
    w_iwe         = 1'b0;
    w_dwe         = 1'b0;
    w_iaddr       = r_iaddr;
    w_idata       = r_idata;
    w_daddr       = r_daddr;
    w_ddata       = r_ddata;
    w_cpu_clr     = r_cpu_clr;
    w_run_done    = r_run_done;
    w_count       = r_count;
    w_clr_cnt     = r_clr_cnt;
`ifdef PROG_LOAD_WATCHDOG_EN
    w_timeout     = r_timeout;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (cmd_valid && r_ready) begin
          case (cmd_op)
            2'b00: begin
              w_iaddr       = cmd_addr;
              w_idata       = cmd_data;
              w_iwe         = 1'b1;
              w_test_normal = 1'b1;
              w_state       = S_WRITE;
            end
            2'b01: begin
              w_daddr       = cmd_addr;
              w_ddata       = cmd_data;
              w_dwe         = 1'b1;
              w_test_normal = 1'b1;
              w_state       = S_WRITE;
            end
            2'b10: begin
              w_test_normal = 1'b0;
              w_count       = '0;
              w_run_done    = 1'b0;
              w_clr_cnt     = '0;
              w_cpu_clr     = 1'b1;
              w_state       = S_CLR;
`ifdef PROG_LOAD_WATCHDOG_EN
              w_timeout     = 1'b0;
`endif
            end
            default: begin
              w_run_done = 1'b0;
              w_state    = S_IDLE;
`ifdef PROG_LOAD_WATCHDOG_EN
              w_timeout  = 1'b0;
`endif
            end
          endcase
        end
      end
      S_WRITE: w_state = S_IDLE;
      S_CLR: begin
        // cpu_done is deliberately not looked at while the core is held in clear
        if (abort) begin
          w_cpu_clr     = 1'b0;
          w_test_normal = 1'b1;
          w_state       = S_IDLE;
        end else if (r_clr_cnt == CLR_LAST) begin
          w_cpu_clr = 1'b0;
          w_state   = S_RUN;
        end else begin
          w_clr_cnt = r_clr_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_test_normal = 1'b1;
          w_state       = S_IDLE;
        end else if (w_done_act) begin
          w_run_done    = 1'b1;
          w_test_normal = 1'b1;
          w_state       = S_DONE;
`ifdef PROG_LOAD_WATCHDOG_EN
        end else if (r_count == WD_LAST) begin
          w_timeout     = 1'b1;
          w_run_done    = 1'b1;
          w_test_normal = 1'b1;
          w_state       = S_DONE;
`endif
        end else begin
          w_count = sat_inc(r_count);
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_ready = (w_state == S_IDLE) || (w_state == S_DONE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_test_normal <= 1'b1;
      r_iwe         <= 1'b0;
      r_dwe         <= 1'b0;
      r_iaddr       <= '0;
      r_idata       <= '0;
      r_daddr       <= '0;
      r_ddata       <= '0;
      r_cpu_clr     <= 1'b0;
      r_run_done    <= 1'b0;
      r_count       <= '0;
      r_clr_cnt     <= '0;
`ifdef PROG_LOAD_WATCHDOG_EN
      r_timeout     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state;
      r_ready       <= w_ready;
      r_test_normal <= w_test_normal;
      r_iwe         <= w_iwe;
      r_dwe         <= w_dwe;
      r_iaddr       <= w_iaddr;
      r_idata       <= w_idata;
      r_daddr       <= w_daddr;
      r_ddata       <= w_ddata;
      r_cpu_clr     <= w_cpu_clr;
      r_run_done    <= w_run_done;
      r_count       <= w_count;
      r_clr_cnt     <= w_clr_cnt;
`ifdef PROG_LOAD_WATCHDOG_EN
      r_timeout     <= w_timeout;
`endif
    end
  end

  assign cmd_ready      = r_ready;
  assign test_normal    = r_test_normal;
  assign ext_instr_we   = r_iwe;
  assign ext_instr_addr = r_iaddr;
  assign ext_instr_data = r_idata;
  assign ext_data_we    = r_dwe;
  assign ext_data_addr  = r_daddr;
  assign ext_data_data  = r_ddata;
  assign cpu_clr        = r_cpu_clr;
  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign run_done       = r_run_done;
  assign cycle_count    = r_count;

endmodule
